// File: rtl/mc_datapath_pkg.sv
// Shared types and encodings for the multi-cycle datapath and its helper blocks.
package mc_datapath_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] J_SEQ   = 2'd0;
  localparam logic [1:0] J_PCREL = 2'd1;
  localparam logic [1:0] J_REG   = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Decoder control vector, bundled once at the top-level boundary.
  typedef struct packed {
    logic       alu_src_b;
    logic       branch;
    logic       branch_n;
    logic       reg_write;
    logic       mem_rw;
    logic [1:0] mem_to_reg;
    logic [1:0] jump;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_sel;
  } ctrl_t;

endpackage

// File: rtl/ALU.sv
// Integer ALU with zero flag.
module ALU
  import mc_datapath_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_SLT:   result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:  result = XLEN'(a < b);
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ImmGen.sv
// Sign-extended immediate extraction for I/S/B/J/U formats.
module ImmGen
  import mc_datapath_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/Regs.sv
// 31-entry register file, x0 hard-wired to zero, two async read ports.
module Regs #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [31:1][XLEN-1:0] rf;

  always_ff @(posedge clk) begin
    if (we && rd != 5'd0) rf[rd] <= wd;
  end

  assign rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];

endmodule

// File: rtl/mc_wait_timer.sv
// Counts consecutive wait cycles of an open memory request and flags a timeout.
module mc_wait_timer #(
  parameter int MAX_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !req || ready) cnt <= '0;
    else if (cnt != LIMIT)    cnt <= cnt + CW'(1);
  end

  // A ready arriving on the limit cycle wins over the timeout.
  assign timeout = (MAX_WAIT != 0) && req && !ready && (cnt == LIMIT);

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32-style datapath: FETCH/DECODE/EXEC/MEM/WB with handshaked
// instruction and data memories and an optional wait-cycle timeout.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic [31:0]     inst_field,
  input  logic            ALUSrc_B,
  input  logic            Branch,
  input  logic            BranchN,
  input  logic            RegWrite,
  input  logic            MemRW,
  input  logic [1:0]      MemtoReg,
  input  logic [1:0]      Jump,
  input  logic [3:0]      ALU_Control,
  input  logic [2:0]      ImmSel,
  output logic [XLEN-1:0] PC_out,
  output logic            retire,
  output logic            err
);
  ctrl_t ctl;
  assign ctl = '{alu_src_b: ALUSrc_B, branch: Branch, branch_n: BranchN,
                 reg_write: RegWrite, mem_rw: MemRW, mem_to_reg: MemtoReg,
                 jump: Jump, alu_ctrl: ALU_Control, imm_sel: ImmSel};

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc, a_q, b_q, imm_q, alu_out, mdr;
  logic            z_q;

  logic [XLEN-1:0] rs1_data, rs2_data, imm_gen, alu_b, alu_res;
  logic [XLEN-1:0] wb_data, pc_plus4, pc_target, pc_next;
  logic            alu_zero, take_br, mem_ready, tmo, rf_we;

  // Requests are pure decodes of the state register, squashed during reset.
  assign imem_req   = !rst && (state == S_FETCH);
  assign dmem_req   = !rst && (state == S_MEM);
  assign dmem_we    = dmem_req && ctl.mem_rw;
  assign imem_addr  = pc;
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b_q;
  assign inst_field = ir;
  assign PC_out     = pc;
  assign retire     = (state == S_WB);

  assign mem_ready = (state == S_FETCH) ? imem_ready : dmem_ready;

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .req     (imem_req | dmem_req),
    .ready   (mem_ready),
    .timeout (tmo)
  );

  Regs #(.XLEN(XLEN)) u_regs (
    .clk (clk),
    .we  (rf_we),
    .rs1 (ir[19:15]),
    .rs2 (ir[24:20]),
    .rd  (ir[11:7]),
    .wd  (wb_data),
    .rd1 (rs1_data),
    .rd2 (rs2_data)
  );

  ImmGen #(.XLEN(XLEN)) u_immgen (
    .inst    (ir[31:7]),
    .imm_sel (ctl.imm_sel),
    .imm     (imm_gen)
  );

  assign alu_b = ctl.alu_src_b ? imm_q : b_q;

  ALU #(.XLEN(XLEN)) u_alu (
    .a        (a_q),
    .b        (alu_b),
    .alu_ctrl (ctl.alu_ctrl),
    .result   (alu_res),
    .zero     (alu_zero)
  );

  assign rf_we = !rst && (state == S_WB) && ctl.reg_write;

  always_comb begin
    wb_data = alu_out;
    case (ctl.mem_to_reg)
      WB_ALU:  wb_data = alu_out;
      WB_MEM:  wb_data = mdr;
      WB_PC4:  wb_data = pc_plus4;
      WB_IMM:  wb_data = imm_q;
      default: wb_data = alu_out;
    endcase
  end

  assign pc_plus4  = pc + XLEN'(4);
  assign pc_target = pc + imm_q;
  assign take_br   = (ctl.branch & z_q) | (ctl.branch_n & ~z_q);

  always_comb begin
    pc_next = take_br ? pc_target : pc_plus4;
    case (ctl.jump)
      J_PCREL: pc_next = pc_target;
      J_REG:   pc_next = {alu_out[XLEN-1:1], 1'b0};
      default: pc_next = take_br ? pc_target : pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      z_q     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end else if (tmo) begin
            err   <= 1'b1;
            state <= S_HALT;
          end
        end
        S_DECODE: begin
          a_q   <= rs1_data;
          b_q   <= rs2_data;
          imm_q <= imm_gen;
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          z_q     <= alu_zero;
          state   <= (ctl.mem_to_reg == WB_MEM || ctl.mem_rw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (!ctl.mem_rw) mdr <= dmem_rdata;
            state <= S_WB;
          end else if (tmo) begin
            err   <= 1'b1;
            state <= S_HALT;
          end
        end
        S_WB: begin
          pc    <= pc_next;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench: small programs in a bench-side instruction memory, hand-computed results.
module tb_mc_datapath;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, inst_field, PC_out;
  logic        ALUSrc_B, Branch, BranchN, RegWrite, MemRW, retire, err;
  logic [1:0]  MemtoReg, Jump;
  logic [3:0]  ALU_Control;
  logic [2:0]  ImmSel;

  mc_datapath #(.XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .inst_field(inst_field),
    .ALUSrc_B(ALUSrc_B), .Branch(Branch), .BranchN(BranchN), .RegWrite(RegWrite), .MemRW(MemRW),
    .MemtoReg(MemtoReg), .Jump(Jump), .ALU_Control(ALU_Control), .ImmSel(ImmSel),
    .PC_out(PC_out), .retire(retire), .err(err)
  );

  always #5 clk = ~clk;

  // Memory responders: ready after a programmable number of wait cycles.
  logic [31:0] imem [0:255];
  int  imem_wait = 0, dmem_wait = 0, iw = 0, dw = 0;
  bit  imem_stall = 1'b0;
  always @(posedge clk) begin
    iw <= (imem_req && !imem_ready) ? iw + 1 : 0;
    dw <= (dmem_req && !dmem_ready) ? dw + 1 : 0;
  end
  assign imem_ready = imem_req && !imem_stall && (iw >= imem_wait);
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_ready = dmem_req && (dw >= dmem_wait);
  assign dmem_rdata = 32'hDEAD_BEEF;

  // External decoder (ALU: 0=add 1=sub; ImmSel: 0=I 1=S 2=B).
  always_comb begin
    ALUSrc_B = 1'b0; Branch = 1'b0; BranchN = 1'b0; RegWrite = 1'b0; MemRW = 1'b0;
    MemtoReg = 2'd0; Jump = 2'd0; ALU_Control = 4'd0; ImmSel = 3'd0;
    case (inst_field[6:0])
      7'h13: begin ALUSrc_B = 1'b1; RegWrite = 1'b1; end
      7'h03: begin ALUSrc_B = 1'b1; RegWrite = 1'b1; MemtoReg = 2'd1; end
      7'h23: begin ALUSrc_B = 1'b1; MemRW = 1'b1; ImmSel = 3'd1; end
      7'h63: begin
        ALU_Control = 4'd1; ImmSel = 3'd2;
        Branch  = (inst_field[14:12] == 3'd0);
        BranchN = (inst_field[14:12] == 3'd1);
      end
      7'h67: begin ALUSrc_B = 1'b1; RegWrite = 1'b1; MemtoReg = 2'd2; Jump = 2'd2; end
      default: ;
    endcase
  end

  localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
  localparam logic [31:0] ADDI_X5_100 = 32'h1000_0293;
  localparam logic [31:0] SW_X1_0     = 32'h0010_2023;
  localparam logic [31:0] SW_X2_4     = 32'h0020_2223;
  localparam logic [31:0] LW_X2_8     = 32'h0080_2103;
  localparam logic [31:0] LW_X1_8     = 32'h0080_2083;
  localparam logic [31:0] BEQ_M8      = 32'hFE00_0CE3;
  localparam logic [31:0] BNE_M8      = 32'hFE00_1CE3;
  localparam logic [31:0] JALR_X1_3X5 = 32'h0032_80E7;

  int checks = 0, errors = 0;
  int dreq_n;
  logic [31:0] d_addr, d_wdata;
  logic        d_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
  endtask

  // Leaves the bench just after rst falls, i.e. inside the first FETCH cycle.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, " rst imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, " rst dmem_req"}, 32'(dmem_req), 32'd0);
    chk({tag, " rst pc"}, PC_out, 32'h0);
    chk({tag, " rst ir"}, inst_field, 32'h0000_0013);
    chk({tag, " rst err"}, 32'(err), 32'd0);
    chk({tag, " rst retire"}, 32'(retire), 32'd0);
    rst = 1'b0;
    #1;
    chk({tag, " first req"}, 32'(imem_req), 32'd1);
  endtask

  // Runs one instruction from its first FETCH cycle; checks latency and next PC.
  task automatic run_instr(input string tag, input int exp_cyc, input logic [31:0] exp_pc);
    int n;
    n = 0; dreq_n = 0;
    forever begin
      n++;
      if (dmem_req) begin
        dreq_n++; d_addr = dmem_addr; d_wdata = dmem_wdata; d_we = dmem_we;
      end
      if (retire || n >= 40) break;
      @(negedge clk);
    end
    chk({tag, " retire cycle"}, 32'(n), 32'(exp_cyc));
    @(negedge clk);
    chk({tag, " pc"}, PC_out, exp_pc);
  endtask

  task automatic wait_dreq(input string tag);
    int n;
    n = 0;
    while (!dmem_req && n < 20) begin @(negedge clk); n++; end
    chk({tag, " dmem_req seen"}, 32'(dmem_req), 32'd1);
  endtask

  initial begin
    int n;
    // Program A: zero-wait ALU, store, waited load, taken branch.
    fill_nop();
    imem[0] = ADDI_X1_5; imem[1] = SW_X1_0; imem[2] = LW_X2_8;
    imem[3] = SW_X2_4;   imem[4] = BEQ_M8;
    do_reset("A");
    run_instr("A addi", 4, 32'h04);
    run_instr("A sw x1", 5, 32'h08);
    chk("A sw addr", d_addr, 32'h0);
    chk("A sw wdata", d_wdata, 32'd5);
    chk("A sw we", 32'(d_we), 32'd1);
    dmem_wait = 3;
    run_instr("A lw", 8, 32'h0C);
    chk("A lw req cycles", 32'(dreq_n), 32'd4);
    chk("A lw addr", d_addr, 32'h8);
    chk("A lw we", 32'(d_we), 32'd0);
    dmem_wait = 0;
    run_instr("A sw x2", 5, 32'h10);
    chk("A sw x2 wdata", d_wdata, 32'hDEAD_BEEF);
    chk("A sw x2 addr", d_addr, 32'h4);
    run_instr("A beq", 4, 32'h08);

    // Program B: one fetch wait state, not-taken bne, jalr with bit-0 clear.
    fill_nop();
    imem[0] = ADDI_X5_100; imem[4] = BNE_M8; imem[5] = JALR_X1_3X5; imem[8'h40] = SW_X1_0;
    imem_wait = 1;
    do_reset("B");
    run_instr("B addi", 5, 32'h04);
    run_instr("B nop1", 5, 32'h08);
    run_instr("B nop2", 5, 32'h0C);
    run_instr("B nop3", 5, 32'h10);
    run_instr("B bne", 5, 32'h14);
    run_instr("B jalr", 5, 32'h102);
    run_instr("B sw link", 6, 32'h106);
    chk("B link value", d_wdata, 32'h18);
    imem_wait = 0;

    // Program C: fetch never ready -> timeout, HALT, then recovery by reset.
    fill_nop();
    imem_stall = 1'b1;
    do_reset("C");
    repeat (3) @(negedge clk);
    chk("C err early", 32'(err), 32'd0);
    n = 0;
    while (!err && n < 20) begin @(negedge clk); n++; end
    chk("C err", 32'(err), 32'd1);
    chk("C halt imem_req", 32'(imem_req), 32'd0);
    chk("C ir untouched", inst_field, 32'h0000_0013);
    repeat (3) @(negedge clk);
    chk("C still halted", 32'(imem_req), 32'd0);
    chk("C err sticky", 32'(err), 32'd1);
    imem_stall = 1'b0;
    imem[0] = ADDI_X1_5;
    do_reset("C rec");
    run_instr("C addi", 4, 32'h04);

    // Program D: reset during the data wait of a store, then of a load.
    fill_nop();
    imem[0] = ADDI_X1_5; imem[1] = SW_X1_0;
    dmem_wait = 2;
    do_reset("D");
    run_instr("D addi", 4, 32'h04);
    wait_dreq("D sw");
    rst = 1'b1;
    @(negedge clk);
    chk("D sw req drop", 32'(dmem_req), 32'd0);
    chk("D sw pc", PC_out, 32'h0);
    chk("D sw retire", 32'(retire), 32'd0);
    imem[1] = LW_X1_8;
    do_reset("D2");
    run_instr("D2 addi", 4, 32'h04);
    wait_dreq("D2 lw");
    rst = 1'b1;
    @(negedge clk);
    chk("D2 lw req drop", 32'(dmem_req), 32'd0);
    imem[0] = SW_X1_0;
    dmem_wait = 0;
    do_reset("D3");
    run_instr("D3 sw", 5, 32'h04);
    chk("D3 x1 kept", d_wdata, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
